gnss_havequick_tod_encoder: RTL and testbench

- Converts GNSS time (10-bit week number plus time-of-week seconds) into a serial time-of-day frame in HaveQuick style.
- Transmits the frame Manchester-encoded on one output pin.
- A one-second strobe from the timing chain triggers each frame.
- Sits between the GNSS receiver time registers and the radio TOD line.

---
 rtl/gnss_hq_pkg.sv | 39 +++
 rtl/manchester_tx.sv | 73 +++++++
 rtl/gnss_havequick_tod_encoder.sv | 163 ++++++++++++++++
 tb/tb_gnss_havequick_tod_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gnss_hq_pkg.sv
// Shared constants, field widths and state encodings for the HaveQuick-style
// GNSS time-of-day encoder.
package gnss_hq_pkg;

  localparam int WN_W   = 10;
  localparam int TOW_W  = 20;
  localparam int DOW_W  = 3;
  localparam int HT_W   = 2;
  localparam int HU_W   = 4;
  localparam int MT_W   = 3;
  localparam int MU_W   = 4;
  localparam int ST_W   = 3;
  localparam int SU_W   = 4;
  localparam int SYNC_W = 8;

  localparam int PAYLOAD_BITS = WN_W + DOW_W + HT_W + HU_W + MT_W + MU_W + ST_W + SU_W;
  localparam int FRAME_BITS   = 58;

  localparam logic [TOW_W-1:0] SECS_PER_DAY  = 20'd86400;
  localparam logic [TOW_W-1:0] SECS_PER_HOUR = 20'd3600;
  localparam logic [TOW_W-1:0] SECS_PER_MIN  = 20'd60;
  localparam logic [TOW_W-1:0] TOW_MAX       = 20'd604799;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    CONVERT,
    SEND
  } hq_state_t;

  // Sub-steps of CONVERT: peel off days, hours, minutes, then split into BCD.
  typedef enum logic [1:0] {
    STEP_DAY,
    STEP_HOUR,
    STEP_MIN,
    STEP_BCD
  } conv_step_t;

endpackage

// File: rtl/manchester_tx.sv
// Serializes a frame MSB first and Manchester-encodes it (IEEE 802.3 polarity:
// a 1 is low then high). The output is registered and idles low.
module manchester_tx
  import gnss_hq_pkg::*;
#(
  parameter int NBITS           = FRAME_BITS,
  parameter int HALF_BIT_CYCLES = 30000
) (
  input  logic             clk_0,
  input  logic             rst_0,
  input  logic             load,
  input  logic [NBITS-1:0] frame,
  output logic             tx,
  output logic             done
);

  localparam int HW = $clog2(HALF_BIT_CYCLES + 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  logic [NBITS-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [HW-1:0]    half_cnt;
  logic             second_half;
  logic             active;

  // Handshake: load is a one-cycle request honoured only while idle; done
  // pulses for exactly one cycle on the edge where tx returns low.
  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      half_cnt    <= '0;
      second_half <= 1'b0;
      active      <= 1'b0;
      tx          <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load && !active) begin
        shreg       <= frame;
        bit_cnt     <= '0;
        half_cnt    <= '0;
        second_half <= 1'b0;
        active      <= 1'b1;
        tx          <= ~frame[NBITS-1];
      end else if (active) begin
        if (half_cnt == HALF_LAST) begin
          half_cnt <= '0;
          if (!second_half) begin
            second_half <= 1'b1;
            tx          <= shreg[NBITS-1];
          end else if (bit_cnt == BIT_LAST) begin
            active      <= 1'b0;
            second_half <= 1'b0;
            tx          <= 1'b0;
            done        <= 1'b1;
          end else begin
            // Next bit's first half is the complement of that bit.
            bit_cnt     <= bit_cnt + BW'(1);
            shreg       <= {shreg[NBITS-2:0], 1'b0};
            second_half <= 1'b0;
            tx          <= ~shreg[NBITS-2];
          end
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/gnss_havequick_tod_encoder.sv
// GNSS week/time-of-week to HaveQuick-style TOD frame: latches the time on a
// start edge, converts it by repeated subtraction and sends it Manchester-coded.
module gnss_havequick_tod_encoder
  import gnss_hq_pkg::*;
#(
  parameter int                HALF_BIT_CYCLES = 30000,
  parameter int                PREAMBLE_BITS   = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD       = 8'hE2
) (
  input  logic             clk_0,
  input  logic             rst_0,
  input  logic             start_0,
  input  logic [WN_W-1:0]  wn10_0,
  input  logic [TOW_W-1:0] tow_sec_0,
  output logic             manchester_out_0
);

  localparam int FRAME_LEN = PREAMBLE_BITS + SYNC_W + PAYLOAD_BITS + 1;

  hq_state_t  state, state_nxt;
  conv_step_t step;

  logic start_q;
  logic trigger;
  logic conv_done;
  logic tx_load;
  logic tx_done;

  logic [WN_W-1:0]  wn_r;
  logic [TOW_W-1:0] rem;
  logic [DOW_W-1:0] dow;
  logic [4:0]       hour;
  logic [5:0]       minute;
  logic [HT_W-1:0]  hour_t;
  logic [MT_W-1:0]  min_t;
  logic [ST_W-1:0]  sec_t;

  logic [PAYLOAD_BITS-1:0] payload;
  logic [FRAME_LEN-1:0]    frame;

  assign trigger = start_0 & ~start_q;

  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      start_q <= 1'b0;
      state   <= IDLE;
    end else begin
      start_q <= start_0;
      state   <= state_nxt;
    end
  end

  // After the BCD split, hour/minute hold units and rem holds second units.
  assign conv_done = (state == CONVERT) && (step == STEP_BCD) &&
                     (hour < 5'd10) && (minute < 6'd10) && (rem < 20'd10);

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    case (state)
      IDLE:    if (trigger) state_nxt = LATCH;
      LATCH:   state_nxt = (rem > TOW_MAX) ? IDLE : CONVERT;
      CONVERT: begin
        if (conv_done) begin
          tx_load   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND:    if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      wn_r   <= '0;
      rem    <= '0;
      dow    <= '0;
      hour   <= '0;
      minute <= '0;
      hour_t <= '0;
      min_t  <= '0;
      sec_t  <= '0;
      step   <= STEP_DAY;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            wn_r   <= wn10_0;
            rem    <= tow_sec_0;
            dow    <= '0;
            hour   <= '0;
            minute <= '0;
            hour_t <= '0;
            min_t  <= '0;
            sec_t  <= '0;
            step   <= STEP_DAY;
          end
        end
        CONVERT: begin
          case (step)
            STEP_DAY: begin
              if (rem >= SECS_PER_DAY) begin
                rem <= rem - SECS_PER_DAY;
                dow <= dow + 3'd1;
              end else begin
                step <= STEP_HOUR;
              end
            end
            STEP_HOUR: begin
              if (rem >= SECS_PER_HOUR) begin
                rem  <= rem - SECS_PER_HOUR;
                hour <= hour + 5'd1;
              end else begin
                step <= STEP_MIN;
              end
            end
            STEP_MIN: begin
              if (rem >= SECS_PER_MIN) begin
                rem    <= rem - SECS_PER_MIN;
                minute <= minute + 6'd1;
              end else begin
                step <= STEP_BCD;
              end
            end
            default: begin
              // All three tens digits are peeled off in parallel.
              if (hour >= 5'd10) begin
                hour   <= hour - 5'd10;
                hour_t <= hour_t + 2'd1;
              end
              if (minute >= 6'd10) begin
                minute <= minute - 6'd10;
                min_t  <= min_t + 3'd1;
              end
              if (rem >= 20'd10) begin
                rem   <= rem - 20'd10;
                sec_t <= sec_t + 3'd1;
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign payload = {wn_r, dow, hour_t, hour[3:0], min_t, minute[3:0], sec_t, rem[3:0]};
  assign frame   = {{PREAMBLE_BITS{1'b1}}, SYNC_WORD, payload, ^payload};

  manchester_tx #(
    .NBITS           (FRAME_LEN),
    .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
  ) u_tx (
    .clk_0 (clk_0),
    .rst_0 (rst_0),
    .load  (tx_load),
    .frame (frame),
    .tx    (manchester_out_0),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_gnss_havequick_tod_encoder.sv
// Directed bench for the TOD encoder: records the output line, decodes the
// Manchester stream and compares it with hand-computed frames.
module tb_gnss_havequick_tod_encoder;

  localparam int HALF     = 8;
  localparam int FB       = 58;
  localparam int SAMP_MAX = 4096;
  localparam int LAT_MAX  = 128;
  localparam int FRAME_CY = 2 * HALF * FB;

  logic       clk_0 = 1'b0;
  logic       rst_0;
  logic       start_0;
  logic [9:0] wn10_0;
  logic [19:0] tow_sec_0;
  logic       manchester_out_0;

  always #5 clk_0 = ~clk_0;

  gnss_havequick_tod_encoder #(.HALF_BIT_CYCLES(HALF)) dut (
    .clk_0            (clk_0),
    .rst_0            (rst_0),
    .start_0          (start_0),
    .wn10_0           (wn10_0),
    .tow_sec_0        (tow_sec_0),
    .manchester_out_0 (manchester_out_0)
  );

  logic        samp [0:SAMP_MAX-1];
  int          n_samp = 0;
  bit          rec_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [57:0] exp_q[$];

  always @(negedge clk_0) begin
    if (rec_en && n_samp < SAMP_MAX) begin
      samp[n_samp] = manchester_out_0;
      n_samp = n_samp + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [57:0] make_frame(input logic [9:0] wn, input logic [2:0] dw,
                                             input logic [1:0] ht, input logic [3:0] hu,
                                             input logic [2:0] mt, input logic [3:0] mu,
                                             input logic [2:0] st, input logic [3:0] su);
    logic [32:0] p;
    p = {wn, dw, ht, hu, mt, mu, st, su};
    return {16'hFFFF, 8'hE2, p, ^p};
  endfunction

  task automatic start_rec();
    @(posedge clk_0);
    n_samp = 0;
    rec_en = 1'b1;
  endtask

  task automatic pulse_start(output int trig_idx);
    @(posedge clk_0);
    #1 start_0 = 1'b1;
    trig_idx = n_samp;
    @(posedge clk_0);
    #1 start_0 = 1'b0;
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(posedge clk_0);
  endtask

  task automatic count_ones(input string tag);
    int ones;
    ones = 0;
    for (int i = 0; i < n_samp; i++) if (samp[i] !== 1'b0) ones++;
    check(tag, 64'(ones), 64'(0));
  endtask

  task automatic decode_check(input string tag, input int trig_idx);
    logic [57:0] got, exp;
    int          k0, base, s;
    bit          shape_ok, tail_ok;
    exp = exp_q.pop_front();
    k0 = -1;
    for (int i = 0; i < n_samp; i++) if (k0 < 0 && samp[i] === 1'b1) k0 = i;
    check({tag, "_found"}, 64'(k0 >= 0), 64'(1));
    if (k0 < 0) return;
    base = k0 - HALF;
    check({tag, "_window"}, 64'(base + FRAME_CY <= n_samp), 64'(1));
    if (base + FRAME_CY > n_samp) return;
    got = '0;
    shape_ok = 1'b1;
    for (int b = 0; b < FB; b++) begin
      s = base + 2 * HALF * b;
      got[FB-1-b] = samp[s+HALF];
      for (int h = 0; h < HALF; h++)
        if (samp[s+h] !== ~samp[s+HALF] || samp[s+HALF+h] !== samp[s+HALF]) shape_ok = 1'b0;
    end
    tail_ok = 1'b1;
    for (int i = base + FRAME_CY; i < n_samp; i++) if (samp[i] !== 1'b0) tail_ok = 1'b0;
    check({tag, "_frame"}, 64'(got), 64'(exp));
    check({tag, "_shape"}, 64'(shape_ok), 64'(1));
    check({tag, "_tail"}, 64'(tail_ok), 64'(1));
    check({tag, "_latency"}, 64'(base - trig_idx <= LAT_MAX), 64'(1));
  endtask

  task automatic run_frame(input string tag, input logic [9:0] wn, input logic [19:0] tow,
                           input logic [57:0] exp);
    int t;
    exp_q.push_back(exp);
    wn10_0 = wn;
    tow_sec_0 = tow;
    start_rec();
    wait_cycles(4);
    pulse_start(t);
    wait_cycles(FRAME_CY + 250);
    rec_en = 1'b0;
    decode_check(tag, t);
  endtask

  logic [57:0] f_nom;

  initial begin
    int t, w;
    rst_0 = 1'b0;
    start_0 = 1'b0;
    wn10_0 = '0;
    tow_sec_0 = '0;
    f_nom = make_frame(10'd314, 3'd2, 2'd1, 4'd3, 3'd0, 4'd6, 3'd4, 4'd7);

    // Reset to idle
    #2 rst_0 = 1'b1;
    #1 check("rst_out", 64'(manchester_out_0), 64'(0));
    #9 rst_0 = 1'b0;
    start_rec();
    wait_cycles(50);
    rec_en = 1'b0;
    count_ones("rst_idle_quiet");

    // Nominal and boundary times
    run_frame("nominal", 10'd314, 20'd220007, f_nom);
    run_frame("tow0", 10'd7, 20'd0, make_frame(10'd7, 3'd0, 2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0));
    run_frame("tow_max", 10'd1023, 20'd604799,
              make_frame(10'd1023, 3'd6, 2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9));
    run_frame("day_end", 10'd0, 20'd86399,
              make_frame(10'd0, 3'd0, 2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9));
    run_frame("day_start", 10'd512, 20'd86400,
              make_frame(10'd512, 3'd1, 2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0));

    // Out-of-range tow produces no frame
    wn10_0 = 10'd314;
    tow_sec_0 = 20'd604800;
    start_rec();
    pulse_start(t);
    wait_cycles(400);
    rec_en = 1'b0;
    count_ones("tow_invalid_quiet");

    // Retrigger mid-frame is ignored
    exp_q.push_back(f_nom);
    tow_sec_0 = 20'd220007;
    start_rec();
    wait_cycles(4);
    pulse_start(t);
    wait_cycles(400);
    pulse_start(w);
    wait_cycles(FRAME_CY - 150);
    rec_en = 1'b0;
    decode_check("retrigger", t);

    // Inputs changed during SEND do not affect the frame
    exp_q.push_back(f_nom);
    tow_sec_0 = 20'd220007;
    start_rec();
    wait_cycles(4);
    pulse_start(t);
    wait_cycles(300);
    tow_sec_0 = 20'd1;
    wn10_0 = 10'd0;
    wait_cycles(FRAME_CY - 50);
    rec_en = 1'b0;
    decode_check("input_change", t);

    // Start held high produces exactly one frame
    exp_q.push_back(f_nom);
    wn10_0 = 10'd314;
    tow_sec_0 = 20'd220007;
    start_rec();
    wait_cycles(4);
    @(posedge clk_0);
    #1 start_0 = 1'b1;
    t = n_samp;
    wait_cycles(FRAME_CY + 400);
    rec_en = 1'b0;
    decode_check("held_start", t);
    start_0 = 1'b0;
    wait_cycles(4);

    // Reset in the second (high) half of bit 30, which is a 1 for wn = 314
    start_rec();
    pulse_start(t);
    w = 0;
    while (manchester_out_0 !== 1'b1 && w < 400) begin
      @(negedge clk_0);
      w++;
    end
    check("rst_mid_found", 64'(w < 400), 64'(1));
    repeat (60 * HALF + HALF / 2) @(negedge clk_0);
    check("rst_mid_pre_hi", 64'(manchester_out_0), 64'(1));
    rst_0 = 1'b1;
    #1 check("rst_mid_forced_low", 64'(manchester_out_0), 64'(0));
    @(posedge clk_0);
    @(posedge clk_0);
    #1 rst_0 = 1'b0;
    rec_en = 1'b0;
    start_rec();
    wait_cycles(300);
    rec_en = 1'b0;
    count_ones("rst_mid_no_resume");
    run_frame("fresh_after_rst", 10'd314, 20'd220007, f_nom);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
